// File: rtl/mult_pipe_pkg.sv
// Shared constants and helpers for the handshaked fixed-point multiplier.
// sat_signed works on a fixed wide signed value so any product width up to MAX_W fits.
package mult_pipe_pkg;

  localparam int RND_TRUNC   = 0;
  localparam int RND_HALF_UP = 1;
  localparam int MAX_W       = 128;

  typedef struct packed {
    logic             ovf;
    logic [MAX_W-1:0] clamped;
  } sat_t;

  function automatic sat_t sat_signed(input logic signed [MAX_W-1:0] value, input int out_w);
    logic signed [MAX_W-1:0] one;
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    sat_t r;
    one = {{(MAX_W-1){1'b0}}, 1'b1};
    hi  = (one <<< (out_w - 1)) - one;
    lo  = -(one <<< (out_w - 1));
    r.ovf     = (value > hi) || (value < lo);
    r.clamped = (value > hi) ? hi : ((value < lo) ? lo : value);
    return r;
  endfunction

  function automatic bit widths_ok(input int a_w, input int b_w, input int out_w,
                                   input int lat, input int fs, input int rnd);
    return (a_w >= 2) && (b_w >= 2) && (out_w >= 1) && (out_w <= a_w + b_w) &&
           (lat >= 1) && (fs >= 0) && (fs <= a_w + b_w - 1) && (a_w + b_w < MAX_W) &&
           ((rnd == RND_TRUNC) || (rnd == RND_HALF_UP));
  endfunction

endpackage

// File: rtl/mult_pipe_hs_if.sv
// Valid/ready operand and result bundle for mult_pipe_hs.
interface mult_pipe_hs_if #(
  parameter int A_W   = 18,
  parameter int B_W   = 18,
  parameter int OUT_W = 36
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [A_W-1:0]   a;
  logic signed [B_W-1:0]   b;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] p;
  logic                    ovf;
  logic                    ovf_sticky;
  logic                    clr_sticky;
  logic                    busy;

  modport master (
    output in_valid, a, b, out_ready, clr_sticky,
    input  in_ready, out_valid, p, ovf, ovf_sticky, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready, clr_sticky,
    output in_ready, out_valid, p, ovf, ovf_sticky, busy
  );
endinterface

// File: rtl/mult_round_sat.sv
// Combinational shift / round-half-up / saturate-or-wrap of a full signed product to OUT_W.
module mult_round_sat
  import mult_pipe_pkg::*;
#(
  parameter int PW         = 36,
  parameter int OUT_W      = 36,
  parameter int FRAC_SHIFT = 0,
  parameter int ROUND      = 0,
  parameter int SATURATE   = 1
) (
  input  logic signed [PW-1:0]    prod,
  output logic signed [OUT_W-1:0] p,
  output logic                    ovf
);
  localparam int RND_POS = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;
  localparam logic signed [PW:0] RND_ADD =
    ((ROUND == RND_HALF_UP) && (FRAC_SHIFT > 0)) ? ({{PW{1'b0}}, 1'b1} << RND_POS) : '0;

  // One extra bit keeps the rounding add from wrapping at the positive extreme.
  logic signed [PW:0] rnd_sum;
  logic signed [PW:0] shifted;
  sat_t               sat_r;
  logic               unused_hi;

  always_comb begin
    rnd_sum = (PW+1)'(prod) + RND_ADD;
    shifted = rnd_sum >>> FRAC_SHIFT;
    sat_r   = sat_signed(MAX_W'(shifted), OUT_W);
    ovf     = sat_r.ovf;
    p       = (SATURATE != 0) ? sat_r.clamped[OUT_W-1:0] : shifted[OUT_W-1:0];
  end

  assign unused_hi = ^sat_r.clamped[MAX_W-1:OUT_W];

endmodule

// File: rtl/mult_pipe_hs.sv
// Pipelined signed fixed-point multiplier with valid/ready flow control and overflow flags.
// The whole pipe advances on one enable so a stalled output freezes every stage.
module mult_pipe_hs
  import mult_pipe_pkg::*;
#(
  parameter int A_W        = 18,
  parameter int B_W        = 18,
  parameter int OUT_W      = 36,
  parameter int LATENCY    = 3,
  parameter int FRAC_SHIFT = 0,
  parameter int ROUND      = 0,
  parameter int SATURATE   = 1
) (
  input logic           clk,
  input logic           rst_n,
  mult_pipe_hs_if.slave bus
);
  localparam int PW = A_W + B_W;

  if (!widths_ok(A_W, B_W, OUT_W, LATENCY, FRAC_SHIFT, ROUND)) begin : g_bad_params
    $error("mult_pipe_hs: parameter out of range");
  end

  logic [LATENCY-1:0]      vld_q;
  logic                    en;
  logic                    in_xfer;
  logic                    out_xfer;
  logic                    pre_vld;
  logic signed [PW-1:0]    prod_in;
  logic signed [PW-1:0]    prod_last;
  logic signed [OUT_W-1:0] p_rs;
  logic                    ovf_rs;
  logic signed [OUT_W-1:0] p_q;
  logic                    ovf_q;
  logic                    sticky_q;

  assign en       = !vld_q[LATENCY-1] || bus.out_ready;
  assign in_xfer  = bus.in_valid && en;
  assign out_xfer = vld_q[LATENCY-1] && bus.out_ready;
  assign prod_in  = PW'(bus.a) * PW'(bus.b);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
    end else if (en) begin
      vld_q[0] <= in_xfer;
      for (int i = 1; i < LATENCY; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  if (LATENCY == 1) begin : g_lat1
    assign prod_last = prod_in;
    assign pre_vld   = in_xfer;
  end else begin : g_latn
    logic signed [PW-1:0] prod_q [LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < LATENCY-1; i++) prod_q[i] <= '0;
      end else if (en) begin
        if (in_xfer) prod_q[0] <= prod_in;
        for (int i = 1; i < LATENCY-1; i++) begin
          if (vld_q[i-1]) prod_q[i] <= prod_q[i-1];
        end
      end
    end

    assign prod_last = prod_q[LATENCY-2];
    assign pre_vld   = vld_q[LATENCY-2];
  end

  mult_round_sat #(
    .PW(PW), .OUT_W(OUT_W), .FRAC_SHIFT(FRAC_SHIFT), .ROUND(ROUND), .SATURATE(SATURATE)
  ) u_round_sat (
    .prod (prod_last),
    .p    (p_rs),
    .ovf  (ovf_rs)
  );

  // P/OVF only load on a valid arrival, so bubbles never disturb a held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q      <= '0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      if (en && pre_vld) begin
        p_q   <= p_rs;
        ovf_q <= ovf_rs;
      end
      if (out_xfer && ovf_q)  sticky_q <= 1'b1;
      else if (bus.clr_sticky) sticky_q <= 1'b0;
    end
  end

  assign bus.in_ready   = en;
  assign bus.out_valid  = vld_q[LATENCY-1];
  assign bus.p          = p_q;
  assign bus.ovf        = ovf_q;
  assign bus.ovf_sticky = sticky_q;
  assign bus.busy       = |vld_q;

endmodule

// File: tb/tb_mult_pipe_hs.sv
// Directed bench for mult_pipe_hs: five parameterisations share one stimulus stream.
module tb_mult_pipe_hs;
  logic clk;
  logic rst_n;
  logic in_valid;
  logic signed [17:0] a;
  logic signed [17:0] b;
  logic out_ready;
  logic clr_sticky;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic signed [17:0] BIG_NEG = -18'sd131072;

  mult_pipe_hs_if #(.A_W(18), .B_W(18), .OUT_W(36)) if_def ();
  mult_pipe_hs_if #(.A_W(18), .B_W(18), .OUT_W(36)) if_r1  ();
  mult_pipe_hs_if #(.A_W(18), .B_W(18), .OUT_W(36)) if_r0  ();
  mult_pipe_hs_if #(.A_W(18), .B_W(18), .OUT_W(16)) if_sat ();
  mult_pipe_hs_if #(.A_W(18), .B_W(18), .OUT_W(16)) if_wrp ();

  assign {if_def.in_valid, if_def.a, if_def.b, if_def.out_ready, if_def.clr_sticky} = {in_valid, a, b, out_ready, clr_sticky};
  assign {if_r1.in_valid,  if_r1.a,  if_r1.b,  if_r1.out_ready,  if_r1.clr_sticky}  = {in_valid, a, b, out_ready, clr_sticky};
  assign {if_r0.in_valid,  if_r0.a,  if_r0.b,  if_r0.out_ready,  if_r0.clr_sticky}  = {in_valid, a, b, out_ready, clr_sticky};
  assign {if_sat.in_valid, if_sat.a, if_sat.b, if_sat.out_ready, if_sat.clr_sticky} = {in_valid, a, b, out_ready, clr_sticky};
  assign {if_wrp.in_valid, if_wrp.a, if_wrp.b, if_wrp.out_ready, if_wrp.clr_sticky} = {in_valid, a, b, out_ready, clr_sticky};

  mult_pipe_hs u_def (.clk(clk), .rst_n(rst_n), .bus(if_def.slave));
  mult_pipe_hs #(.FRAC_SHIFT(1), .ROUND(1)) u_r1 (.clk(clk), .rst_n(rst_n), .bus(if_r1.slave));
  mult_pipe_hs #(.FRAC_SHIFT(1), .ROUND(0)) u_r0 (.clk(clk), .rst_n(rst_n), .bus(if_r0.slave));
  mult_pipe_hs #(.OUT_W(16), .SATURATE(1))  u_sat (.clk(clk), .rst_n(rst_n), .bus(if_sat.slave));
  mult_pipe_hs #(.OUT_W(16), .SATURATE(0))  u_wrp (.clk(clk), .rst_n(rst_n), .bus(if_wrp.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic signed [17:0] va, input logic signed [17:0] vb);
    in_valid = v;
    a        = va;
    b        = vb;
  endtask

  initial begin
    int sent;
    int rcvd;
    logic held_v;
    longint held_p;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1; clr_sticky = 1'b0;
    #12;
    chk("rst_out_valid", if_def.out_valid, 0);
    chk("rst_busy", if_def.busy, 0);
    chk("rst_p", if_def.p, 0);
    chk("rst_sticky", if_def.ovf_sticky, 0);
    chk("rst_in_ready", if_def.in_ready, 1);
    #10 rst_n = 1'b1;
    tick();

    // latency 3 then one result per cycle
    drive(1, 3, -5);     tick();
    chk("t1_v_c1", if_def.out_valid, 0);
    chk("t1_busy_c1", if_def.busy, 1);
    drive(1, 2, 7);      tick();
    chk("t1_v_c2", if_def.out_valid, 0);
    drive(1, -4, -6);    tick();
    chk("t1_v_c3", if_def.out_valid, 1);
    chk("t1_p_c3", if_def.p, -15);
    chk("t1_ovf_c3", if_def.ovf, 0);
    drive(1, 100, -1);   tick();
    chk("t1_p_c4", if_def.p, 14);
    drive(0, 0, 0);      tick();
    chk("t1_p_c5", if_def.p, 24);
    tick();
    chk("t1_v_c6", if_def.out_valid, 1);
    chk("t1_p_c6", if_def.p, -100);
    tick();
    chk("t1_v_c7", if_def.out_valid, 0);
    chk("t1_busy_c7", if_def.busy, 0);

    // rounding, saturation and wrap
    drive(1, 3, 5);              tick();
    drive(1, -3, 5);             tick();
    drive(1, BIG_NEG, BIG_NEG);  tick();
    drive(0, 0, 0);
    chk("t2_rnd_pos", if_r1.p, 8);
    chk("t2_trunc_pos", if_r0.p, 7);
    chk("t2_sat_small", if_sat.p, 15);
    tick();
    chk("t2_rnd_neg", if_r1.p, -7);
    chk("t2_trunc_neg", if_r0.p, -8);
    tick();
    chk("t3_sat_p", if_sat.p, 32767);
    chk("t3_sat_ovf", if_sat.ovf, 1);
    chk("t3_sat_sticky_pre", if_sat.ovf_sticky, 0);
    chk("t3_wrap_p", if_wrp.p, 0);
    chk("t3_wrap_ovf", if_wrp.ovf, 1);
    chk("t3_full_p", if_def.p, 64'sd17179869184);
    chk("t3_full_ovf", if_def.ovf, 0);
    tick();
    chk("t3_sat_sticky", if_sat.ovf_sticky, 1);
    chk("t3_wrap_sticky", if_wrp.ovf_sticky, 1);
    chk("t3_def_sticky", if_def.ovf_sticky, 0);

    // sticky clear, then set winning over a simultaneous clear
    clr_sticky = 1'b1; tick();
    clr_sticky = 1'b0;
    chk("t6_clr", if_sat.ovf_sticky, 0);
    drive(1, BIG_NEG, BIG_NEG); tick();
    drive(0, 0, 0); tick(); tick();
    chk("t6_ovf_out", if_sat.ovf, 1);
    clr_sticky = 1'b1; tick();
    chk("t6_set_wins", if_sat.ovf_sticky, 1);
    tick();
    chk("t6_clr_alone", if_sat.ovf_sticky, 0);
    clr_sticky = 1'b0;

    // random backpressure, results 2,4,..,16 in order
    sent = 0; rcvd = 0; held_v = 1'b0; held_p = 0;
    for (int cyc = 0; cyc < 400 && rcvd < 8; cyc++) begin
      drive(sent < 8, 18'(sent + 1), 18'sd2);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      chk("bp_in_ready", if_def.in_ready, !(if_def.out_valid && !out_ready));
      if (held_v) begin
        chk("bp_hold_valid", if_def.out_valid, 1);
        chk("bp_hold_p", if_def.p, held_p);
      end
      if (if_def.out_valid && out_ready) begin
        chk("bp_p", if_def.p, 2 * (rcvd + 1));
        rcvd++;
      end
      held_v = if_def.out_valid && !out_ready;
      held_p = if_def.p;
      if (in_valid && if_def.in_ready) sent++;
      tick();
    end
    chk("bp_count", rcvd, 8);
    drive(0, 0, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_no_extra", if_def.out_valid, 0);
      tick();
    end

    // reset with three results in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 18'(50 + i), 18'sd1);
      tick();
    end
    drive(0, 0, 0);
    chk("t5_pre_valid", if_def.out_valid, 1);
    chk("t5_pre_p", if_def.p, 50);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valid", if_def.out_valid, 0);
    chk("t5_busy", if_def.busy, 0);
    chk("t5_p", if_def.p, 0);
    chk("t5_in_ready", if_def.in_ready, 1);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_no_ghost", if_def.out_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
